pov_texture_mapper: RTL and testbench

POV_TEXTURE_MAPPER -- requirements
Module: pov_texture_mapper

---
 rtl/pov_pkg.sv | 23 ++
 rtl/pov_frame_sequencer.sv | 110 +++++++++++
 rtl/pov_texture_mapper.sv | 107 ++++++++++
 tb/tb_pov_texture_mapper.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pov_pkg.sv
// Shared types and constants for the POV texture mapper.
package pov_pkg;

   localparam int unsigned COLOR_W = 24;

   typedef enum logic [1:0] {
      MODE_LOOP     = 2'b00,
      MODE_PINGPONG = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_HOLD     = 2'b11
   } pov_mode_e;

   // Per-stage tag carried alongside a pixel request through the ROM pipeline.
   typedef struct packed {
      logic valid;
      logic oor;
   } px_tag_t;

   function automatic int unsigned max1(input int unsigned v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/pov_frame_sequencer.sv
// Frame timer and animation frame sequencing (loop / ping-pong / one-shot / hold).
module pov_frame_sequencer
   import pov_pkg::*;
#(
   parameter int unsigned NUM_FRAMES       = 1,
   parameter int unsigned CYCLES_PER_FRAME = 10,
   parameter int unsigned FI_BITS          = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               play,
   input  pov_mode_e          mode,
   input  logic               frame_load,
   input  logic [FI_BITS-1:0] frame_sel,
   output logic [FI_BITS-1:0] frame_idx,
   output logic               frame_tick,
   output logic               done
);

   localparam int unsigned         TMR_BITS = max1($clog2(CYCLES_PER_FRAME));
   localparam logic [TMR_BITS-1:0] TERM     = TMR_BITS'(CYCLES_PER_FRAME - 1);
   localparam logic [FI_BITS-1:0]  LAST     = FI_BITS'(NUM_FRAMES - 1);
   localparam logic [FI_BITS-1:0]  ONE      = FI_BITS'(1);
   localparam logic                DIR_UP   = 1'b0;
   localparam logic                DIR_DN   = 1'b1;

   logic [TMR_BITS-1:0] timer_q, timer_d;
   logic [FI_BITS-1:0]  idx_q, idx_d;
   logic                tick_q, tick_d;
   logic                done_q, done_d;
   logic                dir_q, dir_d;
   pov_mode_e           mode_q, mode_d;
   logic [FI_BITS-1:0]  sel_clamp;

   assign sel_clamp = (32'(frame_sel) > NUM_FRAMES - 1) ? LAST : frame_sel;

   always_comb begin
      timer_d = timer_q;
      idx_d   = idx_q;
      tick_d  = 1'b0;
      done_d  = done_q;
      dir_d   = dir_q;
      mode_d  = mode;
      if (mode != mode_q) done_d = 1'b0;
      if (frame_load) begin
         // A load restarts the frame period, so it also swallows a coincident tick.
         idx_d   = sel_clamp;
         timer_d = '0;
         done_d  = 1'b0;
         dir_d   = DIR_UP;
      end else if (play) begin
         if (timer_q == TERM) begin
            timer_d = '0;
            tick_d  = 1'b1;
            unique case (mode)
               MODE_LOOP: idx_d = (idx_q == LAST) ? '0 : idx_q + ONE;
               MODE_PINGPONG: begin
                  if (NUM_FRAMES > 1) begin
                     if (dir_q == DIR_UP) begin
                        if (idx_q == LAST) begin
                           idx_d = idx_q - ONE;
                           dir_d = DIR_DN;
                        end else begin
                           idx_d = idx_q + ONE;
                        end
                     end else begin
                        if (idx_q == '0) begin
                           idx_d = ONE;
                           dir_d = DIR_UP;
                        end else begin
                           idx_d = idx_q - ONE;
                        end
                     end
                  end
               end
               MODE_ONESHOT: begin
                  if (idx_q != LAST) idx_d = idx_q + ONE;
                  if (idx_d == LAST) done_d = 1'b1;
               end
               default: ;
            endcase
         end else begin
            timer_d = timer_q + TMR_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
         idx_q   <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         dir_q   <= DIR_UP;
         mode_q  <= MODE_LOOP;
      end else begin
         timer_q <= timer_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
      end
   end

   assign frame_idx  = idx_q;
   assign frame_tick = tick_q;
   assign done       = done_q;

endmodule

// File: rtl/pov_texture_mapper.sv
// POV texture mapper: angle/LED to texture ROM address, pipelined colour return.
module pov_texture_mapper
   import pov_pkg::*;
#(
   parameter int unsigned LED_COUNT   = 52,
   parameter int unsigned TEX_WIDTH   = 64,
   parameter int unsigned NUM_FRAMES  = 1,
   parameter int unsigned THETA_BITS  = 6,
   parameter int unsigned CLK_FREQ    = 100_000_000,
   parameter int unsigned FPS         = 24,
   parameter int unsigned ROM_LATENCY = 1,
   localparam int unsigned FRAME_SIZE       = TEX_WIDTH * LED_COUNT,
   localparam int unsigned CYCLES_PER_FRAME = CLK_FREQ / FPS,
   localparam int unsigned PX_BITS          = $clog2(LED_COUNT),
   localparam int unsigned ADDR_BITS        = $clog2(FRAME_SIZE * NUM_FRAMES),
   localparam int unsigned FI_BITS          = max1($clog2(NUM_FRAMES))
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [THETA_BITS-1:0] theta,
   input  logic [THETA_BITS-1:0] theta_offset,
   input  logic                  px_req,
   input  logic [PX_BITS-1:0]    px_idx,
   input  logic                  play,
   input  logic [1:0]            mode,
   input  logic                  frame_load,
   input  logic [FI_BITS-1:0]    frame_sel,
   output logic [ADDR_BITS-1:0]  rom_addr,
   input  logic [COLOR_W-1:0]    rom_data,
   output logic [COLOR_W-1:0]    px_color,
   output logic                  px_valid,
   output logic [FI_BITS-1:0]    frame_idx,
   output logic                  frame_tick,
   output logic                  done
);

   pov_frame_sequencer #(
      .NUM_FRAMES       (NUM_FRAMES),
      .CYCLES_PER_FRAME (CYCLES_PER_FRAME),
      .FI_BITS          (FI_BITS)
   ) u_seq (
      .clk        (clk),
      .reset      (reset),
      .play       (play),
      .mode       (pov_mode_e'(mode)),
      .frame_load (frame_load),
      .frame_sel  (frame_sel),
      .frame_idx  (frame_idx),
      .frame_tick (frame_tick),
      .done       (done)
   );

   logic [THETA_BITS-1:0] theta_sum;
   logic [31:0]           col;
   logic                  oor;

   logic [ADDR_BITS-1:0]  rom_addr_q, rom_addr_d;
   logic [COLOR_W-1:0]    px_color_q, px_color_d;
   logic                  px_valid_q, px_valid_d;
   px_tag_t               tag_q [ROM_LATENCY];
   px_tag_t               tag_d [ROM_LATENCY];

   // Rotation wraps naturally in THETA_BITS; then scale angle onto texture columns.
   assign theta_sum = theta + theta_offset;
   assign col       = (32'(theta_sum) * TEX_WIDTH) >> THETA_BITS;
   assign oor       = (32'(px_idx) >= LED_COUNT);

   always_comb begin
      rom_addr_d = rom_addr_q;
      if (px_req && !oor) begin
         rom_addr_d = ADDR_BITS'(32'(frame_idx) * FRAME_SIZE + 32'(px_idx) * TEX_WIDTH + col);
      end
   end

   // Tag shift register tracks each request until its ROM data is due.
   always_comb begin
      tag_d[0] = '{valid: px_req, oor: oor};
      for (int i = 1; i < ROM_LATENCY; i++) tag_d[i] = tag_q[i-1];
   end

   always_comb begin
      px_valid_d = tag_q[ROM_LATENCY-1].valid;
      px_color_d = px_color_q;
      if (tag_q[ROM_LATENCY-1].valid) begin
         px_color_d = tag_q[ROM_LATENCY-1].oor ? '0 : rom_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr_q <= '0;
         px_color_q <= '0;
         px_valid_q <= 1'b0;
         for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         px_color_q <= px_color_d;
         px_valid_q <= px_valid_d;
         for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= tag_d[i];
      end
   end

   assign rom_addr = rom_addr_q;
   assign px_color = px_color_q;
   assign px_valid = px_valid_q;

endmodule

// File: tb/tb_pov_texture_mapper.sv
// Directed + randomized bench for pov_texture_mapper against a behavioural model.
module tb_pov_texture_mapper;

   localparam int LED = 52;
   localparam int TW  = 64;
   localparam int NF  = 4;
   localparam int TB  = 6;
   localparam int CPF = 10;
   localparam int FS  = TW * LED;

   localparam logic [1:0] M_LOOP = 2'b00, M_PP = 2'b01, M_ONE = 2'b10, M_HOLD = 2'b11;

   logic        clk = 1'b0;
   logic        reset, play, px_req, frame_load;
   logic [5:0]  theta, theta_offset, px_idx;
   logic [1:0]  mode, frame_sel;
   logic [13:0] rom_addr;
   logic [23:0] rom_data, px_color;
   logic        px_valid, frame_tick, done;
   logic [1:0]  frame_idx;

   always #5 clk = ~clk;

   function automatic logic [23:0] rom_fn(input logic [13:0] a);
      return {a, 10'h000} ^ {10'h000, a} ^ 24'hA5C35A;
   endfunction

   assign rom_data = rom_fn(rom_addr);

   pov_texture_mapper #(
      .LED_COUNT(52), .TEX_WIDTH(64), .NUM_FRAMES(4), .THETA_BITS(6),
      .CLK_FREQ(240), .FPS(24), .ROM_LATENCY(1)
   ) dut (
      .clk(clk), .reset(reset), .theta(theta), .theta_offset(theta_offset),
      .px_req(px_req), .px_idx(px_idx), .play(play), .mode(mode),
      .frame_load(frame_load), .frame_sel(frame_sel), .rom_addr(rom_addr),
      .rom_data(rom_data), .px_color(px_color), .px_valid(px_valid),
      .frame_idx(frame_idx), .frame_tick(frame_tick), .done(done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          due;
      logic [23:0] color;
   } resp_t;
   resp_t       rq[$];
   int          addr_due = -1;
   logic [13:0] addr_next;
   logic [13:0] exp_addr = '0;
   logic [23:0] exp_color = '0;
   int          cur_frame = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: log the request being presented, advance, then compare pixel outputs.
   task automatic step();
      int a;
      int col;
      logic exp_v;
      if (reset) begin
         rq.delete();
         addr_due  = -1;
         exp_addr  = '0;
         exp_color = '0;
      end else if (px_req) begin
         col = (((int'(theta) + int'(theta_offset)) % 64) * TW) >> TB;
         a   = cur_frame * FS + int'(px_idx) * TW + col;
         if (int'(px_idx) < LED) begin
            addr_due  = cyc + 1;
            addr_next = 14'(a);
            rq.push_back('{cyc + 2, rom_fn(14'(a))});
         end else begin
            rq.push_back('{cyc + 2, 24'h0});
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (reset) cur_frame = 0;
      else if (frame_load) cur_frame = int'(frame_sel);
      if (addr_due == cyc) exp_addr = addr_next;
      exp_v = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         exp_v     = 1'b1;
         exp_color = rq[0].color;
         void'(rq.pop_front());
      end
      chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
      chk("px_valid", 32'(px_valid), 32'(exp_v));
      chk("px_color", 32'(px_color), 32'(exp_color));
   endtask

   function automatic int exp_idx(input logic [1:0] m, input int start, input int t);
      int p;
      case (m)
         M_LOOP: return (start + t) % NF;
         M_PP: begin
            p = t % (2 * (NF - 1));
            return (p <= NF - 1) ? p : 2 * (NF - 1) - p;
         end
         M_ONE:   return (start + t > NF - 1) ? NF - 1 : start + t;
         default: return start;
      endcase
   endfunction

   // Load a start frame, then run n cycles checking tick / frame / done per cycle.
   task automatic run_seq(input logic [1:0] m, input int start, input int n, input bit rand_play);
      int  act;
      int  t;
      bit  p;
      mode       = m;
      frame_sel  = 2'(start);
      frame_load = 1'b1;
      play       = 1'b1;
      step();
      frame_load = 1'b0;
      chk("load_idx", 32'(frame_idx), 32'(start));
      chk("load_done", 32'(done), 32'd0);
      act = 0;
      for (int k = 1; k <= n; k++) begin
         p    = rand_play ? ($urandom_range(0, 3) != 0) : 1'b1;
         play = p;
         step();
         if (p) act++;
         t = act / CPF;
         chk("frame_tick", 32'(frame_tick), 32'(p && act > 0 && (act % CPF) == 0));
         chk("frame_idx", 32'(frame_idx), 32'(exp_idx(m, start, t)));
         chk("done", 32'(done), 32'(m == M_ONE && t >= 1 && start + t >= NF - 1));
      end
   endtask

   initial begin
      reset = 1'b1; play = 1'b0; px_req = 1'b0; frame_load = 1'b0;
      theta = '0; theta_offset = '0; px_idx = '0; mode = M_LOOP; frame_sel = '0;
      step();
      step();
      chk("rst_frame_idx", 32'(frame_idx), 32'd0);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;

      run_seq(M_LOOP, 0, 45, 1'b0);
      run_seq(M_PP, 0, 80, 1'b0);
      run_seq(M_ONE, 0, 50, 1'b0);
      run_seq(M_ONE, 1, 5, 1'b0);
      run_seq(M_ONE, 3, 12, 1'b0);
      mode = M_HOLD;
      step();
      chk("mode_change_clears_done", 32'(done), 32'd0);
      chk("mode_change_idx", 32'(frame_idx), 32'd3);
      run_seq(M_LOOP, int'($urandom_range(0, 3)), 60, 1'b1);
      run_seq(M_HOLD, int'($urandom_range(0, 3)), 25, 1'b1);
      run_seq(M_ONE, int'($urandom_range(0, 3)), 40, 1'b1);

      // Load arriving on the terminal count wins over the tick.
      run_seq(M_LOOP, 0, 9, 1'b0);
      frame_sel  = 2'd2;
      frame_load = 1'b1;
      step();
      frame_load = 1'b0;
      chk("load_wins", 32'(frame_idx), 32'd2);
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("after_load_idx", 32'(frame_idx), (k < 10) ? 32'd2 : 32'd3);
      end

      // Pixel path with frame 2 held.
      mode = M_HOLD; play = 1'b0; frame_sel = 2'd2; frame_load = 1'b1;
      step();
      frame_load = 1'b0;
      px_req = 1'b1; px_idx = 6'd5; theta = 6'd60; theta_offset = 6'd10;
      step();
      px_req = 1'b0;
      chk("addr_6982", 32'(rom_addr), 32'd6982);
      step();
      chk("valid_latency", 32'(px_valid), 32'd1);

      for (int i = 0; i < 9; i++) begin
         px_req = 1'b1;
         px_idx = (i < 8) ? 6'(i) : 6'd60;
         theta = 6'($urandom_range(0, 63));
         theta_offset = 6'($urandom_range(0, 63));
         step();
      end
      px_req = 1'b0;
      repeat (3) step();

      for (int i = 0; i < 60; i++) begin
         px_req       = 1'($urandom_range(0, 1));
         px_idx       = 6'($urandom_range(0, 63));
         theta        = 6'($urandom_range(0, 63));
         theta_offset = 6'($urandom_range(0, 63));
         frame_load   = ($urandom_range(0, 7) == 0);
         frame_sel    = 2'($urandom_range(0, 3));
         step();
      end
      px_req = 1'b0; frame_load = 1'b0;
      repeat (3) step();

      // Reset with two requests in flight.
      px_req = 1'b1; px_idx = 6'd3;
      step();
      px_idx = 6'd4; reset = 1'b1;
      step();
      px_req = 1'b0;
      step();
      chk("rst2_frame_idx", 32'(frame_idx), 32'd0);
      chk("rst2_tick", 32'(frame_tick), 32'd0);
      chk("rst2_done", 32'(done), 32'd0);
      reset = 1'b0;
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
